accel_fifo: RTL and testbench

ACCEL_FIFO -- requirements
Module: accel_fifo

---
 rtl/accel_fifo_pkg.sv | 25 ++
 rtl/accel_fifo_mem.sv | 30 +++
 rtl/accel_fifo.sv | 142 ++++++++++++++
 tb/tb_accel_fifo.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/accel_fifo_pkg.sv
// Shared router package: data bus width, default FIFO depth and the router's
// request encodings used by the accelerator-side FIFO.
package accel_fifo_pkg;

   // Router data bus width in bits.
   localparam int DATA_W     = 128;

   // Default number of words buffered between router and accelerator.
   localparam int FIFO_DEPTH = 8;

   // Router request encoding: bit 0 is the put (producer) request, bit 1 the
   // get (consumer) request.
   typedef enum logic [1:0] {
      REQ_IDLE = 2'b00,
      REQ_PUT  = 2'b01,
      REQ_GET  = 2'b10,
      REQ_BOTH = 2'b11
   } req_e;

   // Packs the two request lines into the router encoding.
   function automatic req_e encode_req(input logic put, input logic get);
      return req_e'({get, put});
   endfunction

endpackage : accel_fifo_pkg

// File: rtl/accel_fifo_mem.sv
// Storage array for accel_fifo: WIDTH x DEPTH words, one synchronous write
// port and one asynchronous (combinational) read port.
module accel_fifo_mem #(
   parameter int WIDTH = 128,
   parameter int DEPTH = 8,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic [AW-1:0]    rd_addr,
   output logic [WIDTH-1:0] rd_data
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   // Write the addressed word on the rising edge when enabled.
   // NOTE: the array has no reset; occupancy is tracked by pointers and count,
   // so stale contents are never observable and this maps onto plain RAM.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_addr] <= wr_data;
      end
   end

   // Read is combinational so the owner can register it in the same edge.
   assign rd_data = mem_q[rd_addr];

endmodule : accel_fifo_mem

// File: rtl/accel_fifo.sv
// accel_fifo: synchronous FIFO between router and accelerator. Registered
// read data with a one-cycle valid pulse, registered occupancy and flags,
// and one-cycle error pulses for rejected puts and gets.
module accel_fifo
   import accel_fifo_pkg::*;
#(
   parameter int WIDTH = DATA_W,
   parameter int DEPTH = FIFO_DEPTH,
   localparam int AW   = $clog2(DEPTH),
   localparam int CW   = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             put_req,
   input  logic [WIDTH-1:0] data_in,
   input  logic             get_req,
   output logic [WIDTH-1:0] data_out,
   output logic             data_out_valid,
   output logic             empty,
   output logic             full,
   output logic [CW-1:0]    count,
   output logic             put_err,
   output logic             get_err
);

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q,  count_d;
   logic             empty_q,  empty_d;
   logic             full_q,   full_d;
   logic [WIDTH-1:0] data_out_q, data_out_d;
   logic             valid_q;
   logic             put_err_q;
   logic             get_err_q;

   req_e             req;
   logic             put_ok;
   logic             get_ok;
   logic [WIDTH-1:0] rd_data;

   assign req = encode_req(put_req, get_req);

   // ------------------------------------------------------------------
   // Storage
   // ------------------------------------------------------------------
   accel_fifo_mem #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_mem (
      .clk     (clk),
      .wr_en   (put_ok),
      .wr_addr (wr_ptr_q),
      .wr_data (data_in),
      .rd_addr (rd_ptr_q),
      .rd_data (rd_data)
   );

   // Decide which requests are accepted; a get frees a slot so a put may
   // proceed when full, but an empty FIFO never bypasses write data to read.
   // NOTE: every output of a combinational block gets a default first so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      put_ok = 1'b0;
      get_ok = 1'b0;
      case (req)
         REQ_PUT:  put_ok = !full_q;
         REQ_GET:  get_ok = !empty_q;
         REQ_BOTH: begin
            get_ok = !empty_q;
            put_ok = !full_q || !empty_q;
         end
         default:  ;
      endcase
   end

   // Next-state for pointers, occupancy, flags and read data.
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      data_out_d = data_out_q;

      if (put_ok) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (get_ok) begin
         rd_ptr_d   = rd_ptr_q + AW'(1);
         data_out_d = rd_data;
      end

      case ({put_ok, get_ok})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase

      empty_d = (count_d == '0);
      full_d  = (count_d == CW'(DEPTH));
   end

   // Register all state and outputs; reset forces an empty, quiet FIFO.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         empty_q    <= 1'b1;
         full_q     <= 1'b0;
         data_out_q <= '0;
         valid_q    <= 1'b0;
         put_err_q  <= 1'b0;
         get_err_q  <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         empty_q    <= empty_d;
         full_q     <= full_d;
         data_out_q <= data_out_d;
         valid_q    <= get_ok;
         put_err_q  <= put_req && !put_ok;
         get_err_q  <= get_req && !get_ok;
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign data_out       = data_out_q;
   assign data_out_valid = valid_q;
   assign empty          = empty_q;
   assign full           = full_q;
   assign count          = count_q;
   assign put_err        = put_err_q;
   assign get_err        = get_err_q;

endmodule : accel_fifo

// File: tb/tb_accel_fifo.sv
// Self-checking bench for accel_fifo: directed scenarios plus randomized
// traffic against a queue-based reference model.
module tb_accel_fifo;

   localparam int WIDTH = 128;
   localparam int DEPTH = 8;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic             clk;
   logic             rst_n;
   logic             put_req;
   logic [WIDTH-1:0] data_in;
   logic             get_req;
   logic [WIDTH-1:0] data_out;
   logic             data_out_valid;
   logic             empty;
   logic             full;
   logic [CW-1:0]    count;
   logic             put_err;
   logic             get_err;

   int checks   = 0;
   int failures = 0;

   // Reference model: contents in FIFO order plus expected registered outputs.
   logic [WIDTH-1:0] model_q[$];
   logic [WIDTH-1:0] exp_dout;
   logic             exp_dv;
   logic             exp_perr;
   logic             exp_gerr;

   accel_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .put_req        (put_req),
      .data_in        (data_in),
      .get_req        (get_req),
      .data_out       (data_out),
      .data_out_valid (data_out_valid),
      .empty          (empty),
      .full           (full),
      .count          (count),
      .put_err        (put_err),
      .get_err        (get_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Watchdog so the run can never hang.
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Drive one cycle at the falling edge, advance the model, and return
   // 1 time unit after the rising edge so outputs can be sampled.
   task automatic step(input logic p, input logic [WIDTH-1:0] d, input logic g);
      bit g_ok;
      bit p_ok;
      @(negedge clk);
      put_req = p;
      data_in = d;
      get_req = g;
      g_ok = g && (model_q.size() > 0);
      p_ok = p && ((model_q.size() < DEPTH) || g_ok);
      if (g_ok) exp_dout = model_q.pop_front();
      if (p_ok) model_q.push_back(d);
      exp_dv   = g_ok;
      exp_perr = p && !p_ok;
      exp_gerr = g && !g_ok;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [WIDTH-1:0] w(input int v);
      return WIDTH'(v);
   endfunction

   task automatic test_reset();
      rst_n   = 1'b0;
      put_req = 1'b0;
      get_req = 1'b0;
      data_in = '0;
      model_q.delete();
      exp_dout = '0;
      #12;
      checks++;
      if ({empty, full, count, data_out_valid, put_err, get_err} !== {1'b1, 1'b0, CW'(0), 3'b000}) begin
         failures++;
         $display("FAIL reset_flags: got empty=%b full=%b count=%0d dv=%b perr=%b gerr=%b expected 1 0 0 0 0 0",
                  empty, full, count, data_out_valid, put_err, get_err);
      end
      checks++;
      if (data_out !== '0) begin
         failures++;
         $display("FAIL reset_data_out: got %h expected 0", data_out);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step(1'b0, '0, 1'b0);
         checks++;
         if ({empty, full, count, data_out_valid, put_err, get_err, data_out} !==
             {1'b1, 1'b0, CW'(0), 3'b000, w(0)}) begin
            failures++;
            $display("FAIL idle_after_reset: got empty=%b full=%b count=%0d dv=%b perr=%b gerr=%b dout=%h expected idle empty",
                     empty, full, count, data_out_valid, put_err, get_err, data_out);
         end
      end
   endtask

   task automatic test_fill_drain();
      for (int i = 1; i <= DEPTH; i++) begin
         step(1'b1, w(i), 1'b0);
         checks++;
         if (count !== CW'(i) || full !== (i == DEPTH) || empty !== 1'b0) begin
            failures++;
            $display("FAIL fill_count_%0d: got count=%0d full=%b empty=%b expected count=%0d full=%b empty=0",
                     i, count, full, empty, i, (i == DEPTH));
         end
      end
      for (int i = 1; i <= DEPTH; i++) begin
         step(1'b0, '0, 1'b1);
         checks++;
         if (data_out !== w(i) || data_out_valid !== 1'b1) begin
            failures++;
            $display("FAIL drain_data_%0d: got data=%h dv=%b expected data=%h dv=1", i, data_out, data_out_valid, w(i));
         end
      end
      checks++;
      if (empty !== 1'b1 || count !== CW'(0)) begin
         failures++;
         $display("FAIL drain_empty: got empty=%b count=%0d expected 1 0", empty, count);
      end
      step(1'b0, '0, 1'b0);
      checks++;
      if (data_out_valid !== 1'b0 || data_out !== w(DEPTH)) begin
         failures++;
         $display("FAIL drain_hold: got dv=%b data=%h expected dv=0 data=%h", data_out_valid, data_out, w(DEPTH));
      end
   endtask

   task automatic test_overflow();
      for (int i = 1; i <= DEPTH; i++) step(1'b1, w(i), 1'b0);
      step(1'b1, w(9), 1'b0);
      checks++;
      if (put_err !== 1'b1 || count !== CW'(DEPTH) || full !== 1'b1) begin
         failures++;
         $display("FAIL overflow_reject: got perr=%b count=%0d full=%b expected 1 %0d 1", put_err, count, full, DEPTH);
      end
      step(1'b0, '0, 1'b0);
      checks++;
      if (put_err !== 1'b0) begin
         failures++;
         $display("FAIL overflow_pulse_width: got perr=%b expected 0", put_err);
      end
      for (int i = 1; i <= DEPTH; i++) begin
         step(1'b0, '0, 1'b1);
         checks++;
         if (data_out !== w(i)) begin
            failures++;
            $display("FAIL overflow_drain_%0d: got %h expected %h", i, data_out, w(i));
         end
      end
      checks++;
      if (empty !== 1'b1) begin
         failures++;
         $display("FAIL overflow_no_extra: got empty=%b expected 1", empty);
      end
   endtask

   task automatic test_full_simultaneous();
      for (int i = 1; i <= DEPTH; i++) step(1'b1, w(i), 1'b0);
      step(1'b1, w(10), 1'b1);
      checks++;
      if (data_out !== w(1) || data_out_valid !== 1'b1 || count !== CW'(DEPTH) ||
          full !== 1'b1 || put_err !== 1'b0 || get_err !== 1'b0) begin
         failures++;
         $display("FAIL full_both: got data=%h dv=%b count=%0d full=%b perr=%b gerr=%b expected data=1 dv=1 count=%0d full=1 no errors",
                  data_out, data_out_valid, count, full, put_err, get_err, DEPTH);
      end
      for (int i = 2; i <= DEPTH + 1; i++) begin
         step(1'b0, '0, 1'b1);
         checks++;
         if (data_out !== ((i <= DEPTH) ? w(i) : w(10))) begin
            failures++;
            $display("FAIL full_both_order_%0d: got %h expected %h", i, data_out, (i <= DEPTH) ? w(i) : w(10));
         end
      end
   endtask

   task automatic test_empty_simultaneous();
      step(1'b1, w(5), 1'b1);
      checks++;
      if (get_err !== 1'b1 || put_err !== 1'b0 || data_out_valid !== 1'b0 || count !== CW'(1)) begin
         failures++;
         $display("FAIL empty_both: got gerr=%b perr=%b dv=%b count=%0d expected 1 0 0 1",
                  get_err, put_err, data_out_valid, count);
      end
      step(1'b0, '0, 1'b1);
      checks++;
      if (data_out !== w(5) || data_out_valid !== 1'b1 || get_err !== 1'b0) begin
         failures++;
         $display("FAIL empty_both_read: got data=%h dv=%b gerr=%b expected 5 1 0", data_out, data_out_valid, get_err);
      end
   endtask

   task automatic test_async_reset();
      for (int i = 1; i <= 3; i++) step(1'b1, w(i + 32), 1'b0);
      put_req = 1'b0;
      get_req = 1'b0;
      #1;
      rst_n = 1'b0;
      #1;
      checks++;
      if (empty !== 1'b1 || count !== CW'(0) || data_out !== '0 || full !== 1'b0) begin
         failures++;
         $display("FAIL async_reset: got empty=%b count=%0d dout=%h full=%b expected 1 0 0 0", empty, count, data_out, full);
      end
      #1;
      rst_n = 1'b1;
      model_q.delete();
      exp_dout = '0;
      step(1'b0, '0, 1'b1);
      checks++;
      if (get_err !== 1'b1 || data_out_valid !== 1'b0 || data_out !== '0) begin
         failures++;
         $display("FAIL async_reset_get: got gerr=%b dv=%b dout=%h expected 1 0 0", get_err, data_out_valid, data_out);
      end
   endtask

   task automatic test_random();
      int put_pct;
      int get_pct;
      for (int n = 0; n < 600; n++) begin
         // Phases bias toward filling, draining and balanced traffic.
         case ((n / 50) % 3)
            0:       begin put_pct = 80; get_pct = 25; end
            1:       begin put_pct = 25; get_pct = 80; end
            default: begin put_pct = 60; get_pct = 60; end
         endcase
         step($urandom_range(99) < put_pct, {$urandom(), $urandom(), $urandom(), $urandom()},
              $urandom_range(99) < get_pct);
         checks++;
         if (data_out !== exp_dout || data_out_valid !== exp_dv || put_err !== exp_perr ||
             get_err !== exp_gerr || int'(count) !== model_q.size() ||
             empty !== (model_q.size() == 0) || full !== (model_q.size() == DEPTH)) begin
            failures++;
            $display("FAIL random_cycle_%0d: got dout=%h dv=%b perr=%b gerr=%b count=%0d empty=%b full=%b expected dout=%h dv=%b perr=%b gerr=%b count=%0d",
                     n, data_out, data_out_valid, put_err, get_err, count, empty, full,
                     exp_dout, exp_dv, exp_perr, exp_gerr, model_q.size());
         end
      end
   endtask

   initial begin
      test_reset();
      test_fill_drain();
      test_overflow();
      test_full_simultaneous();
      test_empty_simultaneous();
      test_async_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_accel_fifo
